// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential ALU: opcode encoding,
//                FSM state encoding and the iterative-op classifier.
//                Optional feature macro: ALU_DIV_EN (enables DIVU/REMU).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_RSVD = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SADD = 4'b1011;
    localparam logic [3:0] OP_SSUB = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ops that use the shift-add / restoring unit (before the b==0 check).
    function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Iterative unsigned multiplier (shift-add, LSB first) and,
//                when ALU_DIV_EN is defined, restoring divider. One bit per
//                cycle, WIDTH bits total; the first bit is processed on the
//                start edge directly from the input operands.
//  Ports       : clk, rst_n (async, active-low)
//                start  - begin a new operation (operands sampled)
//                mode   - 0 = multiply, 1 = divide (ignored without ALU_DIV_EN)
//                a, b   - operands
//                done   - final bit is being processed this cycle
//                lo     - product low half / quotient (valid with done)
//                hi     - product high half / remainder (valid with done)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] c_cnt_init = SHW'(WIDTH - 1);

    // r_cnt holds the number of bits still to be processed.
    logic             r_busy;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;

    // Working state: fresh operands on the start edge, registers otherwise.
    logic [WIDTH-1:0] w_cur_hi;
    logic [WIDTH-1:0] w_cur_lo;
    logic [WIDTH-1:0] w_cur_m;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    assign w_cur_hi = start ? '0 : r_hi;

`ifdef ALU_DIV_EN
    logic           r_mode;
    logic           w_cur_mode;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_dsub;

    assign w_cur_mode = start ? mode : r_mode;
    // Divide keeps the dividend in lo (quotient shifts in behind it).
    assign w_cur_lo   = start ? (mode ? a : b) : r_lo;
    assign w_cur_m    = start ? (mode ? b : a) : r_m;
    assign w_madd     = {1'b0, w_cur_hi} + (w_cur_lo[0] ? {1'b0, w_cur_m} : '0);
    assign w_shl      = {w_cur_hi, w_cur_lo[WIDTH-1]};
    // Partial remainder < divisor, so bit WIDTH set means a borrow occurred.
    assign w_dsub     = w_shl - {1'b0, w_cur_m};

    always_comb begin
        w_nxt_hi = w_madd[WIDTH:1];
        w_nxt_lo = {w_madd[0], w_cur_lo[WIDTH-1:1]};
        if (w_cur_mode) begin
            if (!w_dsub[WIDTH]) begin
                w_nxt_hi = w_dsub[WIDTH-1:0];
                w_nxt_lo = {w_cur_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nxt_hi = w_shl[WIDTH-1:0];
                w_nxt_lo = {w_cur_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
        end else if (start) begin
            r_mode <= mode;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_cur_lo      = start ? b : r_lo;
    assign w_cur_m       = start ? a : r_m;
    assign w_madd        = {1'b0, w_cur_hi} + (w_cur_lo[0] ? {1'b0, w_cur_m} : '0);
    // Product accumulates in hi; multiplier bits shift out of lo as product
    // low bits shift in.
    assign w_nxt_hi      = w_madd[WIDTH:1];
    assign w_nxt_lo      = {w_madd[0], w_cur_lo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_m    <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= c_cnt_init;
            r_hi   <= w_nxt_hi;
            r_lo   <= w_nxt_lo;
            r_m    <= w_cur_m;
        end else if (r_busy) begin
            r_hi  <= w_nxt_hi;
            r_lo  <= w_nxt_lo;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == SHW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done = r_busy && (r_cnt == SHW'(1));
    assign lo   = w_nxt_lo;
    assign hi   = w_nxt_hi;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked sequential ALU. Single-cycle ops register their
//                result on the accept edge; MUL (and DIVU/REMU when
//                ALU_DIV_EN is defined) run on alu_muldiv_iter for WIDTH
//                cycles. One op in flight; result held until out_ready.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, op[3:0], a, b   - request side
//                out_valid/out_ready, result,
//                overflow, zero, illegal            - response side
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [1:0]       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_zero;
    logic             r_illegal;

    logic             w_accept;
    logic             w_div_op;
    logic             w_div0;
    logic             w_start;

    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef ALU_DIV_EN
    assign w_div_op = (op == OP_DIVU) || (op == OP_REMU);
`else
    assign w_div_op = 1'b0;
`endif
    // Divide by zero is resolved in one cycle by the single-cycle path.
    assign w_div0  = w_div_op && (b == '0);
    assign w_start = w_accept && is_iterative(op) && !w_div0;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_big;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_ovf;
    logic             w_sc_ill;

    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_big  = |b[WIDTH-1:SHW];
    assign w_sh   = b[SHW-1:0];

    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        w_sc_ill = 1'b0;
        case (op)
            OP_AND:  w_sc_res = a & b;
            OP_OR:   w_sc_res = a | b;
            OP_ADD:  w_sc_res = w_sum;
            OP_XOR:  w_sc_res = a ^ b;
            OP_NOR:  w_sc_res = ~(a | b);
            OP_SUB:  w_sc_res = w_diff;
            OP_SLTU: w_sc_res = {WIDTH{a < b}};
            OP_SHL:  w_sc_res = w_big ? '0 : (a << w_sh);
            OP_SHR:  w_sc_res = w_big ? '0 : (a >> w_sh);
            OP_SRA:  w_sc_res = w_big ? {WIDTH{a[MSB]}} : $unsigned($signed(a) >>> w_sh);
            OP_SADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SSUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
`ifdef ALU_DIV_EN
            // Only reached with b == 0; nonzero divisors go iterative.
            OP_DIVU: begin
                w_sc_res = '1;
                w_sc_ill = 1'b1;
            end
            OP_REMU: begin
                w_sc_res = a;
                w_sc_ill = 1'b1;
            end
`endif
            // OP_MUL lands here too but always starts the iterative unit,
            // so this value is never registered for it.
            default: w_sc_ill = 1'b1;
        endcase
    end

    // ---------------- iterative unit ----------------
    logic             w_it_done;
    logic [WIDTH-1:0] w_it_lo;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_res;
    logic             w_it_ovf;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .mode  (w_div_op),
        .a     (a),
        .b     (b),
        .done  (w_it_done),
        .lo    (w_it_lo),
        .hi    (w_it_hi)
    );

`ifdef ALU_DIV_EN
    logic r_is_div;
    logic r_is_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (w_start) begin
            r_is_div <= w_div_op;
            r_is_rem <= (op == OP_REMU);
        end
    end
`endif

    always_comb begin
        w_it_res = w_it_lo;
        w_it_ovf = |w_it_hi;
`ifdef ALU_DIV_EN
        if (r_is_div) begin
            w_it_ovf = 1'b0;
            if (r_is_rem) begin
                w_it_res = w_it_hi;
            end
        end
`endif
    end

    // ---------------- FSM and output registers ----------------
    // Accept takes priority so a DONE slot can hand straight to a new op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            if (w_start) begin
                r_state     <= ST_BUSY;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_result    <= w_sc_res;
                r_overflow  <= w_sc_ovf;
                r_illegal   <= w_sc_ill;
                r_zero      <= !w_sc_ill && (w_sc_res == '0);
            end
        end else if ((r_state == ST_BUSY) && w_it_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_it_res;
            r_overflow  <= w_it_ovf;
            r_illegal   <= 1'b0;
            r_zero      <= (w_it_res == '0);
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WIDTH=32). Expected results
//                come from a behavioural model and pass through a scoreboard
//                queue. Honours ALU_DIV_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'h0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];
    int   lat_q[$];

    alu_seq #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural reference; lat = cycles from accept to out_valid.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output int lat);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] s;
        e   = '0;
        lat = 1;
        case (o)
            4'h0: e.res = x & y;
            4'h1: e.res = x | y;
            4'h2: e.res = x + y;
            4'h3: e.res = x ^ y;
            4'h4: e.res = ~(x | y);
            4'h6: e.res = x - y;
            4'h7: e.res = (x < y) ? 32'hFFFF_FFFF : 32'h0;
            4'h8: e.res = (y >= 32) ? 32'h0 : (x << y);
            4'h9: e.res = (y >= 32) ? 32'h0 : (x >> y);
            4'hA: e.res = (y >= 32) ? {32{x[31]}} : 32'($signed(x) >>> y);
            4'hB: begin
                s = x + y; e.res = s;
                e.ovf = (x[31] == y[31]) && (s[31] != x[31]);
            end
            4'hC: begin
                s = x - y; e.res = s;
                e.ovf = (x[31] != y[31]) && (s[31] != x[31]);
            end
            4'hD: begin
                p = {32'h0, x} * {32'h0, y};
                e.res = p[31:0]; e.ovf = |p[63:32]; lat = 32;
            end
            4'hE, 4'hF: begin
`ifdef ALU_DIV_EN
                if (y == 32'h0) begin
                    e.res = (o == 4'hE) ? 32'hFFFF_FFFF : x;
                    e.ill = 1'b1;
                end else begin
                    e.res = (o == 4'hE) ? (x / y) : (x % y);
                    lat = 32;
                end
`else
                e.ill = 1'b1;
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = !e.ill && (e.res == 32'h0);
        return e;
    endfunction

    // Drive one request, wait (bounded) for acceptance, push expectation.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output bit ok);
        exp_t e;
        int   l;
        int   n;
        n = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        ok = in_ready;
        @(posedge clk);
        e = model(o, x, y, l);
        sb_q.push_back(e);
        lat_q.push_back(l);
        #1;
        // Scramble inputs so later cycles show they are ignored.
        in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for out_valid; lat counts cycles since the accept edge.
    task automatic collect(output exp_t obs, output int lat, output bit tmo);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
        tmo = !out_valid;
        obs = {result, overflow, zero, illegal};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, result, overflow, zero, illegal} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b res=%h ovf=%b z=%b ill=%b, required all 0",
                     out_valid, result, overflow, zero, illegal);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle;
        logic [3:0]  ops [16] = '{4'hB, 4'hC, 4'hA, 4'h9, 4'h0, 4'h1, 4'h3, 4'h4,
                                  4'h2, 4'h6, 4'h7, 4'h7, 4'h8, 4'h8, 4'hA, 4'h5};
        logic [31:0] xs [16] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'hF0F0_1234, 32'h0F0F_0000, 32'hAAAA_5555, 32'h1234_0000,
                                  32'hFFFF_FFFF, 32'h5, 32'h3, 32'h9,
                                  32'h1, 32'hDEAD_BEEF, 32'h8000_00F0, 32'h1234};
        logic [31:0] ys [16] = '{32'h1, 32'h1, 32'd40, 32'd40,
                                  32'h0FF0_FF00, 32'h0000_F0F0, 32'hFFFF_0000, 32'h0000_5678,
                                  32'h1, 32'h5, 32'h9, 32'h3,
                                  32'd31, 32'd32, 32'd4, 32'h1};
        exp_t obs, e;
        int   lat, el;
        bit   tmo, ok;
        for (int i = 0; i < 16; i++) begin
            send(ops[i], xs[i], ys[i], ok);
            collect(obs, lat, tmo);
            e = sb_q.pop_front(); el = lat_q.pop_front();
            n_checks++;
            if (!ok || tmo || obs !== e) begin
                n_fail++;
                $display("FAIL single[%0d] op=%h: got res=%h ovf=%b z=%b ill=%b, required res=%h ovf=%b z=%b ill=%b",
                         i, ops[i], obs.res, obs.ovf, obs.zero, obs.ill, e.res, e.ovf, e.zero, e.ill);
            end
            n_checks++;
            if (lat !== el) begin
                n_fail++;
                $display("FAIL single_lat[%0d]: got %0d required %0d", i, lat, el);
            end
        end
    endtask

    task automatic test_mul;
        logic [31:0] xs [4] = '{32'h0001_0000, 32'd123456, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] ys [4] = '{32'h0001_0000, 32'd789, 32'hFFFF_FFFF, 32'h5};
        exp_t obs, e;
        int   lat, el;
        bit   tmo, ok;
        for (int i = 0; i < 4; i++) begin
            send(4'hD, xs[i], ys[i], ok);
            collect(obs, lat, tmo);
            e = sb_q.pop_front(); el = lat_q.pop_front();
            n_checks++;
            if (!ok || tmo || obs !== e) begin
                n_fail++;
                $display("FAIL mul[%0d]: got res=%h ovf=%b z=%b ill=%b, required res=%h ovf=%b z=%b ill=%b",
                         i, obs.res, obs.ovf, obs.zero, obs.ill, e.res, e.ovf, e.zero, e.ill);
            end
            n_checks++;
            if (lat !== el) begin
                n_fail++;
                $display("FAIL mul_lat[%0d]: got %0d required %0d", i, lat, el);
            end
        end
    endtask

    task automatic test_div;
        logic [3:0]  ops [5] = '{4'hE, 4'hF, 4'hE, 4'hF, 4'hE};
        logic [31:0] xs [5] = '{32'd100, 32'd100, 32'd100, 32'd100, 32'hFFFF_FFFF};
        logic [31:0] ys [5] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd16};
        exp_t obs, e;
        int   lat, el;
        bit   tmo, ok;
        for (int i = 0; i < 5; i++) begin
            send(ops[i], xs[i], ys[i], ok);
            collect(obs, lat, tmo);
            e = sb_q.pop_front(); el = lat_q.pop_front();
            n_checks++;
            if (!ok || tmo || obs !== e) begin
                n_fail++;
                $display("FAIL div[%0d] op=%h: got res=%h ovf=%b z=%b ill=%b, required res=%h ovf=%b z=%b ill=%b",
                         i, ops[i], obs.res, obs.ovf, obs.zero, obs.ill, e.res, e.ovf, e.zero, e.ill);
            end
            n_checks++;
            if (lat !== el) begin
                n_fail++;
                $display("FAIL div_lat[%0d]: got %0d required %0d", i, lat, el);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t obs, e;
        int   l;
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                op = 4'h2; a = 32'h1000 * (i + 1); b = 32'h11 + i; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                obs = {result, overflow, zero, illegal};
                e = sb_q.pop_front(); l = lat_q.pop_front();
                n_checks++;
                if (!out_valid || obs !== e) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got v=%b res=%h, required v=1 res=%h", i - 1, out_valid, obs.res, e.res);
                end
            end
            if (i < 4) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready);
                end
            end
            @(posedge clk);
            if (i < 4) begin
                sb_q.push_back(model(4'h2, 32'h1000 * (i + 1), 32'h11 + i, l));
                lat_q.push_back(l);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic test_stall;
        exp_t e;
        int   l;
        bit   ok;
        out_ready = 1'b1;
        send(4'h2, 32'hCAFE_0000, 32'h0000_BABE, ok);
        out_ready = 1'b0;
        e = sb_q.pop_front(); l = lat_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op = 4'h0; a = $urandom; b = $urandom; in_valid = 1'b1;
            #1;
            n_checks++;
            if (!ok || {out_valid, in_ready, result, overflow, zero, illegal} !== {1'b1, 1'b0, e}) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b rdy=%b res=%h, required v=1 rdy=0 res=%h",
                         i, out_valid, in_ready, result, e.res);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul;
        exp_t obs, e;
        int   lat, el;
        bit   tmo, ok, seen;
        out_ready = 1'b1;
        send(4'hD, 32'h0001_0000, 32'h0001_0000, ok);
        e = sb_q.pop_front(); el = lat_q.pop_front();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_mul: got v=%b rdy=%b res=%h, required v=0 rdy=1 res=0",
                     out_valid, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abandon: got stray out_valid=%b required 0", seen);
        end
        send(4'h2, 32'd3, 32'd4, ok);
        collect(obs, lat, tmo);
        e = sb_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!ok || tmo || obs !== e) begin
            n_fail++;
            $display("FAIL post_rst_add: got res=%h z=%b ill=%b, required res=%h z=%b ill=%b",
                     obs.res, obs.zero, obs.ill, e.res, e.zero, e.ill);
        end
        n_checks++;
        if (lat !== el) begin
            n_fail++;
            $display("FAIL post_rst_lat: got %0d required %0d", lat, el);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_back_to_back();
        test_stall();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
